// File: rtl/pqc_params_pkg.sv
// Shared ring parameters and stream FSM encoding for the coefficient streamer
// and the adder-side reduction.
package pqc_params_pkg;
    localparam int unsigned p  = 1049089;
    localparam int unsigned N  = 256;
    localparam int unsigned b  = 21;
    localparam int unsigned Nb = N * b;
    localparam int unsigned CW = $clog2(N) + 1;
    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FIN    = 2'd2
    } stream_state_t;
endpackage

// File: rtl/poly_coeff_streamer_if.sv
// Valid/ready coefficient stream between the streamer and the arithmetic units.
interface poly_coeff_streamer_if;
    import pqc_params_pkg::*;

    logic [b-1:0]  coeff_out;
    logic          coeff_valid;
    logic          coeff_ready;
    logic [CW-1:0] coeff_index;
    logic          coeff_last;

    modport master (
        output coeff_out, coeff_valid, coeff_index, coeff_last,
        input  coeff_ready
    );

    modport slave (
        input  coeff_out, coeff_valid, coeff_index, coeff_last,
        output coeff_ready
    );
endinterface

// File: rtl/coeff_cond_sub.sv
// Single conditional subtraction of p; valid because every b-bit value is below 2p.
module coeff_cond_sub
    import pqc_params_pkg::*;
(
    input  logic [b-1:0] c,
    output logic [b-1:0] r,
    output logic         ge_p
);
    localparam logic [b-1:0] P_B = b'(p);

    always_comb begin
        ge_p = (c >= P_B);
        r    = ge_p ? (c - P_B) : c;
    end
endmodule

// File: rtl/poly_coeff_streamer.sv
// Captures one packed polynomial on start and streams reduced coefficients, index 0 first.
//   state  | meaning
//   IDLE   | waiting for start; shadow register holds the previous polynomial
//   STREAM | coeff_valid high, presenting shadow coefficient[index]
//   FIN    | one-cycle done pulse after the index N-1 transfer
module poly_coeff_streamer
    import pqc_params_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [Nb-1:0]                 poly_in,
    poly_coeff_streamer_if.master         cs,
    output logic                          busy,
    output logic                          done,
    output logic                          range_err
);
    stream_state_t state_q, state_d;
    logic [Nb-1:0] shadow_q;
    logic [CW-1:0] idx_q;
    logic [b-1:0]  coeff_q;
    logic          range_err_q;
    logic          load_first;
    logic          advance;
    logic [IW-1:0] next_slot;
    logic [b-1:0]  sel_coeff;
    logic [b-1:0]  red_coeff;
    logic          red_ge_p;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load_first = 1'b0;
        advance    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = STREAM;
                    load_first = 1'b1;
                end
            end
            STREAM: begin
                if (cs.coeff_ready) begin
                    if (idx_q == CW'(N - 1)) state_d = FIN;
                    else                     advance = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Slot wraps at N-1, but that value is never loaded since the last transfer goes to FIN.
    assign next_slot = idx_q[IW-1:0] + 1'b1;
    assign sel_coeff = load_first ? poly_in[0 +: b] : shadow_q[next_slot * b +: b];

    coeff_cond_sub u_cond_sub (
        .c    (sel_coeff),
        .r    (red_coeff),
        .ge_p (red_ge_p)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q    <= '0;
            idx_q       <= '0;
            coeff_q     <= '0;
            range_err_q <= 1'b0;
        end else if (load_first) begin
            shadow_q    <= poly_in;
            idx_q       <= '0;
            coeff_q     <= red_coeff;
            range_err_q <= red_ge_p;
        end else if (advance) begin
            idx_q       <= idx_q + 1'b1;
            coeff_q     <= red_coeff;
            range_err_q <= range_err_q | red_ge_p;
        end
    end

    assign cs.coeff_valid = (state_q == STREAM);
    assign cs.coeff_out   = coeff_q;
    assign cs.coeff_index = idx_q;
    assign cs.coeff_last  = (state_q == STREAM) && (idx_q == CW'(N - 1));
    assign busy           = (state_q == STREAM);
    assign done           = (state_q == FIN);
    assign range_err      = range_err_q;
endmodule

// File: tb/tb_poly_coeff_streamer.sv
// Randomized bench for poly_coeff_streamer against a modulo-arithmetic reference.
module tb_poly_coeff_streamer;
    import pqc_params_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [Nb-1:0] poly_in = '0;
    logic          busy;
    logic          done;
    logic          range_err;
    int            checks = 0;
    int            errors = 0;
    int unsigned   coeffs [N];

    poly_coeff_streamer_if cs_if ();

    poly_coeff_streamer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .poly_in   (poly_in),
        .cs        (cs_if),
        .busy      (busy),
        .done      (done),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic fill_random(input int unsigned hi);
        for (int i = 0; i < N; i++) coeffs[i] = $urandom_range(0, hi);
    endtask

    task automatic scramble_poly_in();
        for (int k = 0; k < Nb; k += 32) poly_in[k +: 32] = $urandom;
    endtask

    // Starts a stream from coeffs[] and follows it to IDLE; returns at the first IDLE negedge.
    task automatic run_stream(input int ready_mode, input bit disturb);
        int          got;
        int          cyc;
        bit          exp_rerr;
        bit          r;
        int unsigned e;
        got = 0;
        cyc = 0;
        exp_rerr = 1'b0;
        for (int i = 0; i < N; i++) poly_in[i * b +: b] = b'(coeffs[i]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (cs_if.coeff_valid !== 1'b1 || cs_if.coeff_index !== '0) begin
            errors++;
            $display("FAIL first_latency valid=%0b index=%0d want 1/0", cs_if.coeff_valid, cs_if.coeff_index);
        end
        while (got < N && cyc < 4 * N) begin
            exp_rerr = exp_rerr | (coeffs[got] >= p);
            e = coeffs[got] % p;
            checks++;
            if (cs_if.coeff_valid !== 1'b1) begin
                errors++;
                $display("FAIL valid idx=%0d got %0b want 1", got, cs_if.coeff_valid);
            end
            checks++;
            if (cs_if.coeff_out !== b'(e)) begin
                errors++;
                $display("FAIL coeff_out idx=%0d got %0d want %0d", got, cs_if.coeff_out, e);
            end
            checks++;
            if (cs_if.coeff_index !== CW'(got)) begin
                errors++;
                $display("FAIL coeff_index got %0d want %0d", cs_if.coeff_index, got);
            end
            checks++;
            if (cs_if.coeff_last !== (got == N - 1)) begin
                errors++;
                $display("FAIL coeff_last idx=%0d got %0b want %0b", got, cs_if.coeff_last, got == N - 1);
            end
            checks++;
            if (range_err !== exp_rerr) begin
                errors++;
                $display("FAIL range_err idx=%0d got %0b want %0b", got, range_err, exp_rerr);
            end
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL busy_done idx=%0d got %0b/%0b want 1/0", got, busy, done);
            end
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            cs_if.coeff_ready = r;
            if (disturb) begin
                start = (got == 100);
                scramble_poly_in();
            end
            @(negedge clk);
            if (r) got++;
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (got != N) begin
            errors++;
            $display("FAIL stream_timeout got %0d transfers want %0d", got, N);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || cs_if.coeff_valid !== 1'b0 || cs_if.coeff_last !== 1'b0) begin
            errors++;
            $display("FAIL fin_state done=%0b busy=%0b valid=%0b last=%0b want 1/0/0/0",
                     done, busy, cs_if.coeff_valid, cs_if.coeff_last);
        end
        checks++;
        if (range_err !== exp_rerr) begin
            errors++;
            $display("FAIL fin_range_err got %0b want %0b", range_err, exp_rerr);
        end
        if (disturb) begin
            start = 1'b1;
            scramble_poly_in();
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cs_if.coeff_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_fin done=%0b busy=%0b valid=%0b want 0/0/0", done, busy, cs_if.coeff_valid);
        end
        checks++;
        if (range_err !== exp_rerr) begin
            errors++;
            $display("FAIL idle_range_err got %0b want %0b", range_err, exp_rerr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cs_if.coeff_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cs_if.coeff_valid !== 1'b0 || cs_if.coeff_out !== '0 || cs_if.coeff_index !== '0 ||
            cs_if.coeff_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || range_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs valid=%0b out=%0d idx=%0d last=%0b busy=%0b done=%0b rerr=%0b want all 0",
                     cs_if.coeff_valid, cs_if.coeff_out, cs_if.coeff_index, cs_if.coeff_last, busy, done, range_err);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (cs_if.coeff_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset valid=%0b busy=%0b want 0/0", cs_if.coeff_valid, busy);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < N; i++) coeffs[i] = i;
        run_stream(0, 1'b0);
        fill_random((1 << b) - 1);
        run_stream(0, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++) coeffs[i] = i;
        run_stream(1, 1'b0);
        fill_random((1 << b) - 1);
        run_stream(2, 1'b0);
    endtask

    task automatic test_range();
        for (int i = 0; i < N; i++) coeffs[i] = 5;
        coeffs[0] = 1049089;
        coeffs[1] = 2097151;
        run_stream(0, 1'b0);
    endtask

    task automatic test_start_ignored();
        fill_random((1 << b) - 1);
        run_stream(2, 1'b1);
        @(negedge clk);
        checks++;
        if (cs_if.coeff_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL no_restart valid=%0b busy=%0b done=%0b want 0/0/0", cs_if.coeff_valid, busy, done);
        end
    endtask

    task automatic test_async_reset();
        int k;
        fill_random((1 << b) - 1);
        for (int i = 0; i < N; i++) poly_in[i * b +: b] = b'(coeffs[i]);
        cs_if.coeff_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (cs_if.coeff_index !== CW'(50) && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (cs_if.coeff_index !== CW'(50) || cs_if.coeff_valid !== 1'b1) begin
            errors++;
            $display("FAIL reach_index50 idx=%0d valid=%0b want 50/1", cs_if.coeff_index, cs_if.coeff_valid);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (cs_if.coeff_valid !== 1'b0 || cs_if.coeff_out !== '0 || cs_if.coeff_index !== '0 ||
            cs_if.coeff_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || range_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset valid=%0b out=%0d idx=%0d last=%0b busy=%0b done=%0b rerr=%0b want all 0",
                     cs_if.coeff_valid, cs_if.coeff_out, cs_if.coeff_index, cs_if.coeff_last, busy, done, range_err);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (cs_if.coeff_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_emit_after_reset valid=%0b busy=%0b want 0/0", cs_if.coeff_valid, busy);
        end
        fill_random((1 << b) - 1);
        run_stream(0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < N; i++) coeffs[i] = $urandom_range(0, 20);
        coeffs[0] = 1049089;
        run_stream(0, 1'b0);
        fill_random(p - 1);
        run_stream(2, 1'b0);
        fill_random((1 << b) - 1);
        run_stream(1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_range();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
